// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle controller: opcodes, FSM states,
// ALU select codes and the instruction field layout.
package cpu_pkg;

  localparam int PC_WIDTH    = 7;
  localparam int IR_WIDTH    = 16;
  localparam int DADDR_WIDTH = 8;
  localparam int RA_WIDTH    = 4;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  // Instruction field LSB positions: op[15:12] | daddr[11:4] or ra[11:8],rb[7:4] | reg[3:0]
  localparam int OP_LSB  = 12;
  localparam int DA_LSB  = 4;
  localparam int RA_LSB  = 8;
  localparam int RB_LSB  = 4;
  localparam int REG_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_t;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_STORE  = 4'd4,
    S_LOAD_A = 4'd5,
    S_LOAD_B = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  function automatic opcode_t f_opcode(input logic [IR_WIDTH-1:0] ir);
    return opcode_t'(ir[OP_LSB +: 4]);
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: asynchronous clear, increments by one on inc and wraps naturally at 2^W.
module program_counter
  import cpu_pkg::*;
#(
  parameter int W = PC_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] pc
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   pc <= '0;
    else if (inc) pc <= pc + W'(1);
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute controller driving the datapath controls.
// One instruction in flight; all controls are Moore outputs of the state and IR.
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = PC_WIDTH,
  parameter int IR_W    = IR_WIDTH,
  parameter int DADDR_W = DADDR_WIDTH,
  parameter int RA_W    = RA_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    PC_Addr,
  input  logic [IR_W-1:0]    IR_Data,
  output logic [DADDR_W-1:0] D_Addr,
  output logic               D_WriteEn,
  output logic               MuxS,
  output logic [RA_W-1:0]    RegF_W_addr,
  output logic               RegF_W_en,
  output logic [RA_W-1:0]    RegF_Ra_addr,
  output logic [RA_W-1:0]    RegF_Rb_addr,
  output logic [2:0]         ALU_S,
  output logic               Halted,
  output logic [3:0]         State
);

  state_t          r_state;
  state_t          w_next_state;
  logic [IR_W-1:0] r_ir;
  logic            w_pc_inc;

  assign w_pc_inc = (r_state == S_DECODE);
  assign State    = r_state;

  program_counter #(.W(PC_W)) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_pc_inc),
    .pc    (PC_Addr)
  );

  // NOTE: async reset clears state and IR, so the Moore outputs drop to 0 the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_ir    <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) r_ir <= IR_Data;
    end
  end

  // NOTE: every output gets a default before the case, so no path leaves a latch behind.
  always_comb begin
    w_next_state = S_INIT;
    D_Addr       = '0;
    D_WriteEn    = 1'b0;
    MuxS         = 1'b0;
    RegF_W_addr  = '0;
    RegF_W_en    = 1'b0;
    RegF_Ra_addr = '0;
    RegF_Rb_addr = '0;
    ALU_S        = ALU_PASS;
    Halted       = 1'b0;
    unique case (r_state)
      S_INIT:   w_next_state = S_FETCH;
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: begin
        case (f_opcode(IR_Data))
          OP_STORE: w_next_state = S_STORE;
          OP_LOAD:  w_next_state = S_LOAD_A;
          OP_ADD:   w_next_state = S_ADD;
          OP_SUB:   w_next_state = S_SUB;
          OP_HALT:  w_next_state = S_HALT;
          default:  w_next_state = S_NOOP;
        endcase
      end
      S_NOOP:   w_next_state = S_FETCH;
      S_STORE: begin
        D_Addr       = r_ir[DA_LSB +: DADDR_W];
        RegF_Ra_addr = r_ir[REG_LSB +: RA_W];
        D_WriteEn    = 1'b1;
        w_next_state = S_FETCH;
      end
      // LOAD_A gives the data memory a cycle of read latency before the RF captures it
      S_LOAD_A, S_LOAD_B: begin
        D_Addr       = r_ir[DA_LSB +: DADDR_W];
        RegF_W_addr  = r_ir[REG_LSB +: RA_W];
        MuxS         = 1'b1;
        RegF_W_en    = (r_state == S_LOAD_B);
        w_next_state = (r_state == S_LOAD_A) ? S_LOAD_B : S_FETCH;
      end
      S_ADD, S_SUB: begin
        RegF_Ra_addr = r_ir[RA_LSB +: RA_W];
        RegF_Rb_addr = r_ir[RB_LSB +: RA_W];
        RegF_W_addr  = r_ir[REG_LSB +: RA_W];
        RegF_W_en    = 1'b1;
        ALU_S        = (r_state == S_ADD) ? ALU_ADD : ALU_SUB;
        w_next_state = S_FETCH;
      end
      S_HALT: begin
        Halted       = 1'b1;
        w_next_state = S_HALT;
      end
      default:  w_next_state = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: registered ROM model plus a per-cycle expected trace
// derived from the instruction semantics (program walk, not state-machine replay).
module tb_control_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [6:0]  PC_Addr;
  logic [15:0] IR_Data;
  logic [7:0]  D_Addr;
  logic        D_WriteEn;
  logic        MuxS;
  logic [3:0]  RegF_W_addr;
  logic        RegF_W_en;
  logic [3:0]  RegF_Ra_addr;
  logic [3:0]  RegF_Rb_addr;
  logic [2:0]  ALU_S;
  logic        Halted;
  logic [3:0]  State;

  control_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PC_Addr      (PC_Addr),
    .IR_Data      (IR_Data),
    .D_Addr       (D_Addr),
    .D_WriteEn    (D_WriteEn),
    .MuxS         (MuxS),
    .RegF_W_addr  (RegF_W_addr),
    .RegF_W_en    (RegF_W_en),
    .RegF_Ra_addr (RegF_Ra_addr),
    .RegF_Rb_addr (RegF_Rb_addr),
    .ALU_S        (ALU_S),
    .Halted       (Halted),
    .State        (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] rom [0:127];
  always @(posedge clk) IR_Data <= rom[PC_Addr];

  typedef struct packed {
    state_t     st;
    logic [6:0] pc;
    logic [7:0] da;
    logic       dwe;
    logic       mux;
    logic [3:0] wa;
    logic       wen;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
    logic       halted;
  } exp_t;

  exp_t exp_q [$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input state_t s, input int pc);
    exp_t e;
    e    = '0;
    e.st = s;
    e.pc = 7'(pc);
    return e;
  endfunction

  // Walk the program: FETCH, DECODE, then the opcode's execute cycles; PC advances after DECODE.
  task automatic build_trace(input int max_len);
    exp_t        e;
    int          pc;
    logic [15:0] ir;
    logic [3:0]  op;
    bit          halted;
    pc     = 0;
    halted = 1'b0;
    exp_q.delete();
    exp_q.push_back(mk(S_INIT, 0));
    while (exp_q.size() < max_len && !halted) begin
      exp_q.push_back(mk(S_FETCH, pc));
      exp_q.push_back(mk(S_DECODE, pc));
      ir = rom[pc];
      op = ir[15:12];
      pc = (pc + 1) % 128;
      case (op)
        4'd1: begin
          e = mk(S_STORE, pc); e.da = ir[11:4]; e.ra = ir[3:0]; e.dwe = 1'b1;
          exp_q.push_back(e);
        end
        4'd2: begin
          e = mk(S_LOAD_A, pc); e.da = ir[11:4]; e.wa = ir[3:0]; e.mux = 1'b1;
          exp_q.push_back(e);
          e.st = S_LOAD_B; e.wen = 1'b1;
          exp_q.push_back(e);
        end
        4'd3, 4'd4: begin
          e = mk((op == 4'd3) ? S_ADD : S_SUB, pc);
          e.ra = ir[11:8]; e.rb = ir[7:4]; e.wa = ir[3:0]; e.wen = 1'b1;
          e.alu = (op == 4'd3) ? 3'd1 : 3'd2;
          exp_q.push_back(e);
        end
        4'd5: begin
          e = mk(S_HALT, pc); e.halted = 1'b1;
          for (int k = 0; k < 20; k++) exp_q.push_back(e);
          halted = 1'b1;
        end
        default: exp_q.push_back(mk(S_NOOP, pc));
      endcase
    end
    while (exp_q.size() > max_len) void'(exp_q.pop_back());
  endtask

  task automatic cmp_entry(input string name, input int cyc, input exp_t e);
    string t;
    t = $sformatf("%s[%0d]", name, cyc);
    check({t, ".state"},  32'(State),        32'(e.st));
    check({t, ".pc"},     32'(PC_Addr),      32'(e.pc));
    check({t, ".daddr"},  32'(D_Addr),       32'(e.da));
    check({t, ".dwe"},    32'(D_WriteEn),    32'(e.dwe));
    check({t, ".muxs"},   32'(MuxS),         32'(e.mux));
    check({t, ".waddr"},  32'(RegF_W_addr),  32'(e.wa));
    check({t, ".wen"},    32'(RegF_W_en),    32'(e.wen));
    check({t, ".ra"},     32'(RegF_Ra_addr), 32'(e.ra));
    check({t, ".rb"},     32'(RegF_Rb_addr), 32'(e.rb));
    check({t, ".alu"},    32'(ALU_S),        32'(e.alu));
    check({t, ".halted"}, 32'(Halted),       32'(e.halted));
    check({t, ".onewr"},  32'(D_WriteEn & RegF_W_en), 32'(0));
  endtask

  // Holds reset for two cycles, checks the INIT cycle, releases reset, then follows the trace.
  task automatic run_trace(input string name);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      cmp_entry(name, i, exp_q[i]);
      if (i == 0) rst_n = 1'b1;
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
  endtask

  initial begin
    logic [15:0] w;
    rst_n = 1'b0;

    // 1: single NOOP after reset
    clear_rom();
    build_trace(5);
    run_trace("noop");

    // 2-4: LOAD, ADD, SUB, STORE, then HALT holding PC for 20 cycles
    clear_rom();
    rom[0] = 16'h20B1;
    rom[1] = 16'h3145;
    rom[2] = 16'h4326;
    rom[3] = 16'h1CD0;
    rom[4] = 16'h5000;
    build_trace(1000);
    run_trace("prog");

    // 5: illegal opcode decodes as NOOP; PC wraps 127 -> 0
    clear_rom();
    rom[0]   = 16'hF123;
    rom[127] = 16'h3A5C;
    build_trace(388);
    run_trace("wrap");

    // 6: reset dropped between edges during LOAD_A
    clear_rom();
    rom[1] = 16'h20B1;
    build_trace(7);
    run_trace("rstmid");
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.state",  32'(State),     32'(S_INIT));
    check("rstmid.pc",     32'(PC_Addr),   32'(0));
    check("rstmid.daddr",  32'(D_Addr),    32'(0));
    check("rstmid.muxs",   32'(MuxS),      32'(0));
    check("rstmid.waddr",  32'(RegF_W_addr), 32'(0));
    check("rstmid.wen",    32'(RegF_W_en), 32'(0));
    @(negedge clk);
    check("rstmid.wen2",   32'(RegF_W_en), 32'(0));
    check("rstmid.state2", 32'(State),     32'(S_INIT));

    // Randomized programs; HALT is made rare so most of the trace is live instructions
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 128; i++) begin
        w = 16'($urandom);
        if (w[15:12] == 4'h5 && $urandom_range(0, 9) != 0) w[15:12] = 4'h3;
        rom[i] = w;
      end
      build_trace(500);
      run_trace($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
